// File: rtl/hs_fifo_mcsfifo.sv
// Multi-channel synchronous FIFO: CH_NUM queues behind one write port, drained by a
// round-robin show-ahead read port. Define HS_FIFO_MCSFIFO_LEVEL_EN to add the level output.
module hs_fifo_mcsfifo #(
   parameter type          DATA_TYPE        = logic [15:0],
   parameter int unsigned  FIFO_DEPTH       = 32,
   parameter int unsigned  CH_NUM           = 4,
   parameter int unsigned  ALMOST_FULL_LVL  = FIFO_DEPTH,
   parameter int unsigned  ALMOST_EMPTY_LVL = 0,
   parameter bit           EN_PACKET_MODE   = 1'b0,
   localparam int unsigned DW               = $bits(DATA_TYPE),
   localparam int unsigned CW               = (CH_NUM > 2) ? $clog2(CH_NUM) : 1,
   localparam int unsigned CNTW             = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [CW-1:0]          s_chan,
   input  DATA_TYPE               s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [CW-1:0]          m_chan,
   output DATA_TYPE               m_data,
   output logic                   m_last,
   output logic [CH_NUM-1:0]      full,
   output logic [CH_NUM-1:0]      empty,
   output logic [CH_NUM-1:0]      almost_full,
   output logic [CH_NUM-1:0]      almost_empty,
`ifdef HS_FIFO_MCSFIFO_LEVEL_EN
   output logic [CH_NUM*CNTW-1:0] level,
`endif
   output logic                   chan_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef logic [DW:0] word_t;

   word_t             r_mem    [CH_NUM][FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr [CH_NUM];
   logic [AW-1:0]     r_rd_ptr [CH_NUM];
   logic [CNTW-1:0]   r_cnt    [CH_NUM];
   logic [CNTW-1:0]   w_cnt_d  [CH_NUM];

   logic [CW-1:0]     r_rr_ptr, r_hold_ch;
   logic              r_hold, r_lock, r_chan_err;
   logic [CH_NUM-1:0] r_full, r_empty, r_afull, r_aempty;

   logic [CW-1:0]     w_scan, w_gnt, w_next;
   logic              w_found, w_gnt_ne, w_oor, w_full_sel, w_wr, w_valid, w_pop;
   logic [CH_NUM-1:0] w_ne, w_wr_sel, w_pop_sel;
   word_t             w_word;

   // Write side: out-of-range channels are always accepted and then dropped.
   always_comb begin
      w_oor      = 32'(s_chan) >= CH_NUM;
      w_full_sel = 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (s_chan == CW'(c)) w_full_sel = r_full[c];
      end
      s_ready = !rst && (w_oor || !w_full_sel);
      w_wr    = s_valid && s_ready && !w_oor;
   end

   always_comb begin
      w_scan  = r_rr_ptr;
      w_found = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         w_ne[i] = (r_cnt[i] != '0);
      end
      for (int i = 0; i < CH_NUM; i++) begin
         if (!w_found && w_ne[(32'(r_rr_ptr) + 32'(i)) % CH_NUM]) begin
            w_scan  = CW'((32'(r_rr_ptr) + 32'(i)) % CH_NUM);
            w_found = 1'b1;
         end
      end
   end

   // A held grant always points at a non-empty channel, so w_gnt_ne doubles as m_valid.
   always_comb begin
      if (r_hold)                        w_gnt = r_hold_ch;
      else if (EN_PACKET_MODE && r_lock) w_gnt = r_rr_ptr;
      else                               w_gnt = w_scan;
      w_gnt_ne = 1'b0;
      w_word   = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (w_gnt == CW'(c)) begin
            w_gnt_ne = w_ne[c];
            w_word   = r_mem[c][r_rd_ptr[c]];
         end
      end
      w_valid = w_gnt_ne;
      w_pop   = w_valid && m_ready;
      w_next  = CW'((32'(w_gnt) + 32'd1) % CH_NUM);
      for (int c = 0; c < CH_NUM; c++) begin
         w_wr_sel[c]  = w_wr && (s_chan == CW'(c));
         w_pop_sel[c] = w_pop && (w_gnt == CW'(c));
         w_cnt_d[c]   = r_cnt[c] + CNTW'(w_wr_sel[c]) - CNTW'(w_pop_sel[c]);
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CH_NUM; c++) begin
         if (w_wr_sel[c]) r_mem[c][r_wr_ptr[c]] <= {s_last, s_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
            r_cnt[c]    <= '0;
            r_full[c]   <= 1'b0;
            r_empty[c]  <= 1'b1;
            r_afull[c]  <= (ALMOST_FULL_LVL == 0);
            r_aempty[c] <= 1'b1;
         end
         r_rr_ptr   <= '0;
         r_hold_ch  <= '0;
         r_hold     <= 1'b0;
         r_lock     <= 1'b0;
         r_chan_err <= 1'b0;
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (w_wr_sel[c])  r_wr_ptr[c] <= r_wr_ptr[c] + AW'(1);
            if (w_pop_sel[c]) r_rd_ptr[c] <= r_rd_ptr[c] + AW'(1);
            r_cnt[c]    <= w_cnt_d[c];
            r_full[c]   <= (32'(w_cnt_d[c]) == FIFO_DEPTH);
            r_empty[c]  <= (w_cnt_d[c] == '0);
            r_afull[c]  <= (32'(w_cnt_d[c]) >= ALMOST_FULL_LVL);
            r_aempty[c] <= (32'(w_cnt_d[c]) <= ALMOST_EMPTY_LVL);
         end
         r_chan_err <= s_valid && s_ready && w_oor;
         if (w_pop) begin
            r_hold <= 1'b0;
            if (EN_PACKET_MODE && !w_word[DW]) begin
               r_lock   <= 1'b1;
               r_rr_ptr <= w_gnt;
            end else begin
               r_lock   <= 1'b0;
               r_rr_ptr <= w_next;
            end
         end else if (w_valid) begin
            r_hold    <= 1'b1;
            r_hold_ch <= w_gnt;
         end
      end
   end

   assign m_valid      = w_valid;
   assign m_chan       = w_valid ? w_gnt : '0;
   assign m_data       = w_valid ? DATA_TYPE'(w_word[DW-1:0]) : '0;
   assign m_last       = w_valid && w_word[DW];
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign chan_err     = r_chan_err;

`ifdef HS_FIFO_MCSFIFO_LEVEL_EN
   for (genvar c = 0; c < CH_NUM; c++) begin : g_level
      assign level[c*CNTW +: CNTW] = r_cnt[c];
   end
`endif

endmodule
